minisys_hilo_muldiv: RTL
========================

// Module: minisys_hilo_muldiv
// PURPOSE
//  EXE-stage HI/LO unit: iterative multiply/divide engine plus the HI and LO architectural registers.
//  Executes MULT/MULTU/DIV/DIVU (radix-2, one bit per cycle), MTHI/MTLO, and supplies HI/LO to the
//  EXE/MEM pipeline register feeding hi2rdataM/lo2rdataM. Stalls the pipeline while an operation runs.
// PARAMETERS
//  WIDTH     32  operand/HI/LO width; iteration count equals WIDTH
//  CNT_W      6  iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  clrn         in   1      asynchronous active-low reset
//  start_mult   in   1      signed multiply request (ID/EXE decoded)
//  start_multu  in   1      unsigned multiply request
//  start_div    in   1      signed divide request
//  start_divu   in   1      unsigned divide request
//  mthi         in   1      write op_a to HI
//  mtlo         in   1      write op_a to LO
//  mfhi_req     in   1      instruction in EXE reads HI
//  mflo_req     in   1      instruction in EXE reads LO
//  flush        in   1      abort in-flight operation (branch/exception squash)
//  op_a         in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO data)
//  op_b         in   WIDTH  rt value (multiplier / divisor)
//  hi_out       out  WIDTH  HI register
//  lo_out       out  WIDTH  LO register
//  busy         out  1      engine not IDLE
//  stall        out  1      hold IF/ID/EXE this cycle
//  done         out  1      one-cycle pulse: HI/LO just updated by an engine result
// BEHAVIOUR
//  Reset (clrn=0, async): state=IDLE, hi_out=0, lo_out=0, counter=0, busy=0, done=0.
//  FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: on edge with a start_* high (and flush=0): latch |op_a|,|op_b| (abs value for signed ops only),
//     result signs and op type; counter=0; -> RUN. Priority if several asserted:
//     start_div > start_divu > start_mult > start_multu; remaining starts ignored.
//   RUN: one shift-add (mult) / restoring subtract-shift (div) step per edge; after WIDTH steps -> FIX.
//   FIX: sign correction; write HI/LO on the edge leaving FIX; -> IDLE; done=1 for the following cycle.
//  Latency: start accepted at edge E0 -> HI/LO valid after edge E0+WIDTH+1 (33 edges at WIDTH=32);
//   busy high for exactly WIDTH+1 cycles.
//  MULT/MULTU: {HI,LO} = 2*WIDTH-bit product; signed product negated when operand signs differ.
//  DIV/DIVU: LO = quotient, HI = remainder. Signed: quotient negative iff signs differ; remainder takes
//   dividend's sign. 0x80000000 / -1 -> LO=0x80000000, HI=0 (natural wrap).
//  Divide by zero: same latency; HI=op_a (original, unsigned-interpreted), LO=all ones.
//  MTHI/MTLO: in IDLE, HI (resp. LO) <= op_a at the edge; same-cycle start also accepted, its result
//   later overwrites. mthi & mtlo together both write.
//  stall = busy & (any start_* | mthi | mtlo | mfhi_req | mflo_req); combinational. Requests seen while
//   stall=1 are not accepted; upstream holds them. stall drops in the done cycle (HI/LO already valid).
//  flush: in RUN/FIX -> IDLE at next edge, HI/LO unchanged, no done. In IDLE, flush drops any same-cycle
//   start/mthi/mtlo.
//  Reset mid-operation: immediate IDLE, HI/LO=0, no done.
// TESTING
//  1 MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE LO=00000001 after 33 edges; busy 33 cycles; one done pulse.
//  2 MULT -3*7 -> HI=FFFFFFFF LO=FFFFFFEB; MULT 0*80000000 -> HI=LO=0.
//  3 DIV -7/2 -> LO=FFFFFFFD HI=FFFFFFFF; DIVU 7/0 -> HI=00000007 LO=FFFFFFFF; DIV 80000000/FFFFFFFF -> LO=80000000 HI=0.
//  4 mfhi_req held from cycle 5 of MULT -> stall=1 until done cycle, then 0; MTHI 1234 in RUN ignored, in IDLE HI=00001234.
//  5 flush at RUN step 5 after prior HI=AAAA LO=BBBB -> IDLE next cycle, HI/LO unchanged, done never pulses.
//  6 clrn low at RUN step 10 -> busy=0, HI=LO=0 immediately; new DIVU 100/7 after release -> LO=E HI=2.

Source files
------------

// File: rtl/minisys_hilo_muldiv_if.sv
// Pipeline-side bundle of the HI/LO multiply/divide unit: requests and operands in, HI/LO and status out.
interface minisys_hilo_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_mult;
    logic             start_multu;
    logic             start_div;
    logic             start_divu;
    logic             mthi;
    logic             mtlo;
    logic             mfhi_req;
    logic             mflo_req;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start_mult, start_multu, start_div, start_divu,
        output mthi, mtlo, mfhi_req, mflo_req, flush, op_a, op_b,
        input  hi_out, lo_out, busy, stall, done
    );

    modport slave (
        input  start_mult, start_multu, start_div, start_divu,
        input  mthi, mtlo, mfhi_req, mflo_req, flush, op_a, op_b,
        output hi_out, lo_out, busy, stall, done
    );
endinterface

// File: rtl/minisys_hilo_muldiv.sv
// EXE-stage HI/LO unit: radix-2 iterative multiply/divide engine plus the HI and LO registers.
module minisys_hilo_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 clrn,
    minisys_hilo_muldiv_if.slave bus
);
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic               isDiv, isDivNext;
    logic               negQ, negQNext;
    logic               negR, negRNext;
    logic               divZero, divZeroNext;
    logic [WIDTH-1:0]   origA, origANext;
    logic [WIDTH-1:0]   opB, opBNext;
    logic [WIDTH-1:0]   accHi, accHiNext;
    logic [WIDTH-1:0]   accLo, accLoNext;
    logic [WIDTH-1:0]   hiReg, hiNext;
    logic [WIDTH-1:0]   loReg, loNext;
    logic               doneReg, doneNext;

    logic               anyStart, divOp, sgnOp, aNeg, bNeg, busy;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum, divShift;
    logic               divGe;
    logic [PROD_W-1:0]  prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;

    // Request decode with priority div > divu > mult > multu
    assign anyStart = bus.start_div | bus.start_divu | bus.start_mult | bus.start_multu;
    assign divOp    = bus.start_div | bus.start_divu;
    assign sgnOp    = bus.start_div | (~bus.start_divu & bus.start_mult);
    assign aNeg     = sgnOp & bus.op_a[WIDTH-1];
    assign bNeg     = sgnOp & bus.op_b[WIDTH-1];
    assign absA     = aNeg ? -bus.op_a : bus.op_a;
    assign absB     = bNeg ? -bus.op_b : bus.op_b;

    // Mult keeps the multiplier in accLo and shifts the product in from the top;
    // div shifts the dividend out of accLo into the partial remainder accHi.
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divGe    = divShift >= {1'b0, opB};

    assign prodFix  = negQ ? -{accHi, accLo} : {accHi, accLo};
    assign quotFix  = negQ ? -accLo : accLo;
    assign remFix   = negR ? -accHi : accHi;

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        isDivNext   = isDiv;
        negQNext    = negQ;
        negRNext    = negR;
        divZeroNext = divZero;
        origANext   = origA;
        opBNext     = opB;
        accHiNext   = accHi;
        accLoNext   = accLo;
        hiNext      = hiReg;
        loNext      = loReg;
        doneNext    = 1'b0;

        case (state)
            IDLE: begin
                if (!bus.flush) begin
                    if (bus.mthi) hiNext = bus.op_a;
                    if (bus.mtlo) loNext = bus.op_a;
                    if (anyStart) begin
                        stateNext   = RUN;
                        cntNext     = '0;
                        isDivNext   = divOp;
                        negQNext    = aNeg ^ bNeg;
                        negRNext    = divOp & aNeg;
                        divZeroNext = divOp & (bus.op_b == '0);
                        origANext   = bus.op_a;
                        opBNext     = divOp ? absB : absA;
                        accHiNext   = '0;
                        accLoNext   = divOp ? absA : absB;
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    stateNext = IDLE;
                end else begin
                    if (isDiv) begin
                        accHiNext = divGe ? WIDTH'(divShift - {1'b0, opB}) : divShift[WIDTH-1:0];
                        accLoNext = {accLo[WIDTH-2:0], divGe};
                    end else begin
                        accHiNext = mulSum[WIDTH:1];
                        accLoNext = {mulSum[0], accLo[WIDTH-1:1]};
                    end
                    cntNext = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) stateNext = FIX;
                end
            end
            FIX: begin
                stateNext = IDLE;
                if (!bus.flush) begin
                    doneNext = 1'b1;
                    if (divZero) begin
                        hiNext = origA;
                        loNext = '1;
                    end else if (isDiv) begin
                        hiNext = remFix;
                        loNext = quotFix;
                    end else begin
                        {hiNext, loNext} = prodFix;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            isDiv   <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            origA   <= '0;
            opB     <= '0;
            accHi   <= '0;
            accLo   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            isDiv   <= isDivNext;
            negQ    <= negQNext;
            negR    <= negRNext;
            divZero <= divZeroNext;
            origA   <= origANext;
            opB     <= opBNext;
            accHi   <= accHiNext;
            accLo   <= accLoNext;
            hiReg   <= hiNext;
            loReg   <= loNext;
            doneReg <= doneNext;
        end
    end

    assign busy       = (state != IDLE);
    assign bus.busy   = busy;
    assign bus.hi_out = hiReg;
    assign bus.lo_out = loReg;
    assign bus.done   = doneReg;
    // Hold the pipeline only while an EXE instruction actually depends on this unit
    assign bus.stall  = busy & (anyStart | bus.mthi | bus.mtlo | bus.mfhi_req | bus.mflo_req);
endmodule
